id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register fed by the register file read ports. Bypasses same-cycle WB writes into the
//  read data, detects load-use hazards (stalls upstream, inserts bubble), honours Flush/Hold, counts stalls.
// PARAMETERS
//  DATA_WIDTH        32  operand/result width
//  REG_SELECT_WIDTH   5  register specifier width
//  IMM_WIDTH         16  raw immediate width, sign-extended to DATA_WIDTH
// PORTS
//  Clk         in   1    clock, all state updates on posedge
//  Reset       in   1    asynchronous, active-low reset
//  InValid     in   1    ID holds a real instruction
//  ReadSelect1 in   RSW  rs specifier (same value driven to register file)
//  ReadSelect2 in   RSW  rt specifier
//  UsesRt      in   1    instruction reads rt (enables rt hazard check)
//  ReadData1   in   DW   register file rs data
//  ReadData2   in   DW   register file rt data
//  WriteSelect in   RSW  WB destination (same as register file write port)
//  WriteEnable in   1    WB write strobe
//  WriteData   in   DW   WB data
//  Rd          in   RSW  destination specifier
//  Imm         in   IW   raw immediate
//  CtrlIn      in   8    {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,ALUOp[2:0]}
//  Flush       in   1    kill instruction entering EX (branch taken)
//  Hold        in   1    downstream busy: freeze this register
//  Stall       out  1    to IF/ID: hold instruction in ID (combinational)
//  ExValid     out  1    registered valid
//  ExA, ExB    out  DW   registered operands after WB bypass
//  ExImm       out  DW   registered sign-extended immediate
//  ExRs,ExRt,ExRd out RSW registered specifiers
//  ExCtrl      out  8    registered control bundle
//  StallCount  out  16   load-use bubbles inserted, saturating
// BEHAVIOUR
//  - Reset low (async): ExValid=0, ExCtrl=0, ExA/ExB/ExImm=0, ExRs/ExRt/ExRd=0, StallCount=0; held while low.
//  - Bypass A: WriteEnable & WriteSelect!=0 & WriteSelect==ReadSelect1 ? WriteData : ReadData1. B likewise.
//    Register 0 never bypassed.
//  - LoadUse = InValid & ExValid & ExCtrl[MemRead] & ExRd!=0 &
//    (ExRd==ReadSelect1 | (UsesRt & ExRd==ReadSelect2)).
//  - Stall = ~Flush & (Hold | LoadUse). Flush forces Stall=0.
//  - Posedge priority (latency 1 cycle):
//    1 Flush: ExValid=0, ExCtrl=0; datapath regs don't-care (hold).
//    2 Hold: all regs keep value.
//    3 LoadUse: bubble (ExValid=0, ExCtrl=0); StallCount += 1, saturates at 16'hFFFF.
//    4 else: load bypassed operands, specifiers, ExImm=sign-extended Imm, ExCtrl=InValid?CtrlIn:0, ExValid=InValid.
//  - Bubble clears ExCtrl[MemRead], so a stalled load-use resolves after exactly one bubble.
//  - Hold & LoadUse together: Hold wins, no bubble, no count; evaluated again next cycle.
//  - InValid=0: no hazard; loads an invalid entry with ExCtrl=0.
//  - Reset mid-stall: state clears immediately; Stall falls since ExValid=0.
// TESTING
//  1 Reset=0 while ExValid=1 -> all outputs 0 without a clock edge; release, first edge loads normally.
//  2 rs=5, ReadData1=0x11, WB writes r5=0xAB same cycle -> ExA=0xAB next edge; WriteSelect=0 -> ExA=ReadData1.
//  3 lw r3 in EX, ID add rs=3 -> Stall=1, next edge ExValid=0, StallCount=1; next edge add enters, Stall=0.
//  4 lw r3 in EX, ID rt=3 with UsesRt=0 -> no stall; ExRd=0 load -> no stall.
//  5 Flush=1 with LoadUse and Hold both true -> Stall=0, ExValid=0, ExCtrl=0, StallCount unchanged.
//  6 Hold=1 for 3 cycles -> outputs frozen, Stall=1; StallCount preset 0xFFFF + load-use -> stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register fed by the register file read ports.
//   Bypasses same-cycle WB writes into the operand data, detects load-use
//   hazards (stalls upstream and inserts a bubble), honours flush/hold and
//   counts inserted bubbles in a saturating counter.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid                    ID holds a real instruction
//   read_select1/2, uses_rt     rs/rt specifiers; uses_rt enables the rt hazard check
//   read_data1/2                register file rs/rt data
//   write_select/enable/data    WB write port (bypass source)
//   rd, imm, ctrl_in            destination, raw immediate, control bundle
//                               ctrl_in = {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,ALUOp[2:0]}
//   flush, hold                 kill the entering instruction / freeze this register
//   stall_c                     combinational stall request to IF/ID
//   ex_*                        registered EX-side copy of the instruction
//   stall_count                 load-use bubbles inserted, saturating
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned REG_SELECT_WIDTH  = 5,
    parameter int unsigned IMM_WIDTH         = 16,
    parameter int unsigned STALL_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [REG_SELECT_WIDTH-1:0]  read_select1,
    input  logic [REG_SELECT_WIDTH-1:0]  read_select2,
    input  logic                         uses_rt,
    input  logic [DATA_WIDTH-1:0]        read_data1,
    input  logic [DATA_WIDTH-1:0]        read_data2,
    input  logic [REG_SELECT_WIDTH-1:0]  write_select,
    input  logic                         write_enable,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic [REG_SELECT_WIDTH-1:0]  rd,
    input  logic [IMM_WIDTH-1:0]         imm,
    input  logic [7:0]                   ctrl_in,
    input  logic                         flush,
    input  logic                         hold,
    output logic                         stall_c,
    output logic                         ex_valid,
    output logic [DATA_WIDTH-1:0]        ex_a,
    output logic [DATA_WIDTH-1:0]        ex_b,
    output logic [DATA_WIDTH-1:0]        ex_imm,
    output logic [REG_SELECT_WIDTH-1:0]  ex_rs,
    output logic [REG_SELECT_WIDTH-1:0]  ex_rt,
    output logic [REG_SELECT_WIDTH-1:0]  ex_rd,
    output logic [7:0]                   ex_ctrl,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

    localparam int unsigned MEM_READ_BIT = 6;
    localparam int unsigned EXT_WIDTH    = DATA_WIDTH - IMM_WIDTH;
    localparam logic [STALL_COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic                  bypass1;
    logic                  bypass2;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic                  load_use;

    // WB bypass; register 0 is hard-wired and never forwarded
    assign bypass1   = write_enable && (write_select != '0) && (write_select == read_select1);
    assign bypass2   = write_enable && (write_select != '0) && (write_select == read_select2);
    assign operand_a = bypass1 ? write_data : read_data1;
    assign operand_b = bypass2 ? write_data : read_data2;
    assign imm_ext   = {{EXT_WIDTH{imm[IMM_WIDTH-1]}}, imm};

    // Load in EX whose destination feeds the instruction in ID
    always_comb begin
        load_use = 1'b0;
        if (in_valid && ex_valid && ex_ctrl[MEM_READ_BIT] && (ex_rd != '0)) begin
            load_use = (ex_rd == read_select1) || (uses_rt && (ex_rd == read_select2));
        end
    end

    // Flush overrides any stall request since the ID instruction is dead
    assign stall_c = !flush && (hold || load_use);

    // Pipeline register: flush > hold > bubble > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            stall_count <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (!hold) begin
            if (load_use) begin
                // Bubble clears MemRead, so the hazard resolves after one cycle
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                if (stall_count != COUNT_MAX) begin
                    stall_count <= stall_count + STALL_COUNT_WIDTH'(1);
                end
            end else begin
                ex_valid <= in_valid;
                ex_ctrl  <= in_valid ? ctrl_in : 8'h00;
                ex_a     <= operand_a;
                ex_b     <= operand_b;
                ex_imm   <= imm_ext;
                ex_rs    <= read_select1;
                ex_rt    <= read_select2;
                ex_rd    <= rd;
            end
        end
    end

endmodule
